shift_seq: RTL

Iterative shift sequencer for the execute stage. It accepts one shift request (SLL/SRL/SRA) through a valid/ready handshake. It performs the shift over several cycles using a narrow per-cycle shifter of at most `STEP` bits, then holds the result until the consumer takes it. It lets the core trade the full barrel shifter for area while keeping a clean handshake toward the ALU issue logic.

---
 rtl/shift_seq.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/shift_seq.sv
// -----------------------------------------------------------------------------
// shift_seq -- iterative shift sequencer for the execute stage.
//
// Accepts one SLL/SRL/SRA request through a valid/ready handshake, performs
// the shift at most STEP bits per cycle, then holds the result until the
// consumer takes it.
//
// Optional build macro: SHIFT_SEQ_BARREL_EN
//   defined     : full XLEN-bit barrel shift on the accept edge; IDLE->DONE
//                 always, SHIFT unreachable, STEP has no effect on latency.
//   not defined : iterative STEP-bit-per-cycle operation.
//
// Parameters:
//   XLEN  operand width
//   STEP  maximum bits shifted per cycle (power of two, 1..XLEN/2)
//   SW    shift-amount width, derived as $clog2(XLEN)
//
// Ports:
//   clk         clock, rising edge
//   rst         asynchronous active-high reset
//   req_valid   request present
//   req_ready   sequencer can accept a request (IDLE and not in reset)
//   req_op      00 SLL, 01 SRL, 11 SRA, 10 pass-through (shamt treated as 0)
//   req_a       operand
//   req_shamt   shift amount
//   resp_valid  result available
//   resp_ready  consumer accepts result
//   resp_b      shift result
//   busy        sequencer not idle
// -----------------------------------------------------------------------------
module shift_seq #(
    parameter int  XLEN = 32,
    parameter int  STEP = 4,
    localparam int SW   = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [SW-1:0]   req_shamt,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_b,
    output logic            busy
);

    // Width of the per-cycle shift amount: holds 0..STEP.
    localparam int KW = $clog2(STEP) + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    state_t          state_r, state_next_s;
    logic [XLEN-1:0] work_r, work_next_s;
    logic [1:0]      op_r, op_next_s;
    logic [SW-1:0]   rem_r, rem_next_s;
    logic            valid_r, busy_r;
    logic [KW-1:0]   k_s;
    logic [XLEN-1:0] shifted_s;

`ifdef SHIFT_SEQ_BARREL_EN
    // Single-cycle reference shift used on the accept edge.
    function automatic logic [XLEN-1:0] barrel_shift(
        input logic [1:0]      op,
        input logic [XLEN-1:0] a,
        input logic [SW-1:0]   sh
    );
        logic [XLEN-1:0] res;
        case (op)
            2'b00:   res = a << sh;
            2'b01:   res = a >> sh;
            2'b11:   res = $unsigned($signed(a) >>> sh);
            default: res = a;
        endcase
        return res;
    endfunction
`endif

    assign req_ready  = (state_r == ST_IDLE) && !rst;
    assign resp_valid = valid_r;
    assign resp_b     = work_r;
    assign busy       = busy_r;

    // Per-cycle shift distance k = min(STEP, rem); rem fits in KW bits when <= STEP.
    always_comb begin
        k_s = {KW{1'b0}};
        if (rem_r > SW'(STEP)) begin
            k_s = KW'(STEP);
        end else begin
            k_s = rem_r[KW-1:0];
        end
    end

    // Narrow shifter: moves the work register by at most STEP bits.
    always_comb begin
        shifted_s = work_r;
        case (op_r)
            2'b00:   shifted_s = work_r << k_s;
            2'b01:   shifted_s = work_r >> k_s;
            2'b11:   shifted_s = $unsigned($signed(work_r) >>> k_s);
            default: shifted_s = work_r;
        endcase
    end

    // Next-state and datapath update for the IDLE/SHIFT/DONE sequencer.
    always_comb begin
        state_next_s = state_r;
        work_next_s  = work_r;
        op_next_s    = op_r;
        rem_next_s   = rem_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    op_next_s = req_op;
`ifdef SHIFT_SEQ_BARREL_EN
                    work_next_s  = barrel_shift(req_op, req_a, req_shamt);
                    rem_next_s   = {SW{1'b0}};
                    state_next_s = ST_DONE;
`else
                    work_next_s = req_a;
                    // Pass-through op and zero shift finish immediately.
                    if ((req_op == 2'b10) || (req_shamt == {SW{1'b0}})) begin
                        rem_next_s   = {SW{1'b0}};
                        state_next_s = ST_DONE;
                    end else begin
                        rem_next_s   = req_shamt;
                        state_next_s = ST_SHIFT;
                    end
`endif
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                work_next_s = shifted_s;
                // k never exceeds rem, so rem cannot underflow.
                rem_next_s  = rem_r - SW'(k_s);
                if (rem_next_s == {SW{1'b0}}) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (resp_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered-output flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            work_r  <= {XLEN{1'b0}};
            op_r    <= 2'b00;
            rem_r   <= {SW{1'b0}};
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            work_r  <= work_next_s;
            op_r    <= op_next_s;
            rem_r   <= rem_next_s;
            valid_r <= (state_next_s == ST_DONE);
            busy_r  <= (state_next_s != ST_IDLE);
        end
    end

endmodule
